// File: rtl/div_job_sequencer.sv
// Queues divide requests, issues them one at a time to the sequential divider core,
// and returns quotient/remainder/error over a valid/ready result port.
module div_job_sequencer #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_dividend,
  input  logic [W-1:0]     in_divisor,
  output logic             core_start,
  output logic [2*W-1:0]   core_dividend,
  output logic [W-1:0]     core_divisor,
  input  logic             core_done,
  input  logic             core_divby0,
  input  logic             core_overflow,
  output logic             core_finish,
  input  logic [W-1:0]     core_quotient,
  input  logic [W-1:0]     core_remainder,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_quotient,
  output logic [W-1:0]     res_remainder,
  output logic [1:0]       res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIVBY0  = 2'b01;
  localparam logic [1:0] ERR_OVERFLW = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RESP} state_t;

  state_t state, next_state;

  logic [2*W-1:0] fifo_dividend [DEPTH];
  logic [W-1:0]   fifo_divisor  [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty, push, pop;

  logic [TW-1:0]  timer, timer_nxt;
  logic           start_nxt, finish_nxt, valid_nxt;
  logic [2*W-1:0] dividend_nxt;
  logic [W-1:0]   divisor_nxt, quotient_nxt, remainder_nxt;
  logic [1:0]     err_nxt;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == ISSUE);

  // Storage is not reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dividend[wr_ptr] <= in_dividend;
      fifo_divisor[wr_ptr]  <= in_divisor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      core_start    <= 1'b0;
      core_finish   <= 1'b0;
      res_valid     <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_err       <= ERR_OK;
    end else begin
      state         <= next_state;
      timer         <= timer_nxt;
      core_start    <= start_nxt;
      core_finish   <= finish_nxt;
      res_valid     <= valid_nxt;
      core_dividend <= dividend_nxt;
      core_divisor  <= divisor_nxt;
      res_quotient  <= quotient_nxt;
      res_remainder <= remainder_nxt;
      res_err       <= err_nxt;
    end
  end

  // Completion beats error flags, and any real flag beats the timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT: begin
        if (core_done)                           next_state = RESP;
        else if (core_divby0 || core_overflow)   next_state = ACK;
        else if (timer == TW'(TIMEOUT - 1))      next_state = ACK;
      end
      ACK:     next_state = RESP;
      RESP:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_nxt     = (next_state == ISSUE) && (state == IDLE);
    finish_nxt    = (next_state == ACK);
    valid_nxt     = (next_state == RESP);
    timer_nxt     = timer;
    dividend_nxt  = core_dividend;
    divisor_nxt   = core_divisor;
    quotient_nxt  = res_quotient;
    remainder_nxt = res_remainder;
    err_nxt       = res_err;
    case (state)
      IDLE: begin
        if (!empty) begin
          dividend_nxt = fifo_dividend[rd_ptr];
          divisor_nxt  = fifo_divisor[rd_ptr];
        end
      end
      ISSUE: timer_nxt = '0;
      WAIT: begin
        timer_nxt = timer + 1'b1;
        if (core_done) begin
          quotient_nxt  = core_quotient;
          remainder_nxt = core_remainder;
          err_nxt       = ERR_OK;
        end else if (next_state == ACK) begin
          quotient_nxt  = '0;
          remainder_nxt = '0;
          if (core_divby0)        err_nxt = ERR_DIVBY0;
          else if (core_overflow) err_nxt = ERR_OVERFLW;
          else                    err_nxt = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Directed bench for div_job_sequencer: the bench plays the divider core and the
// result consumer, and checks each scenario against hand-computed values.
module tb_div_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_dividend = '0;
  logic [7:0]  in_divisor = '0;
  logic        core_start;
  logic [15:0] core_dividend;
  logic [7:0]  core_divisor;
  logic        core_done = 1'b0;
  logic        core_divby0 = 1'b0;
  logic        core_overflow = 1'b0;
  logic        core_finish;
  logic [7:0]  core_quotient = '0;
  logic [7:0]  core_remainder = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_quotient;
  logic [7:0]  res_remainder;
  logic [1:0]  res_err;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  div_job_sequencer #(.W(8), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_done(core_done), .core_divby0(core_divby0), .core_overflow(core_overflow),
    .core_finish(core_finish), .core_quotient(core_quotient), .core_remainder(core_remainder),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quotient(res_quotient), .res_remainder(res_remainder), .res_err(res_err)
  );

  // Advance to the next falling edge, dropping in_valid once the request was taken.
  task automatic tick();
    bit acc;
    acc = in_valid && in_ready;
    @(negedge clk);
    if (acc) begin
      in_valid = 1'b0;
      accepted++;
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [7:0] v);
    in_dividend = d;
    in_divisor  = v;
    in_valid    = 1'b1;
    tick();
  endtask

  // mode: 0 done, 1 divby0, 2 overflow, 3 both flags, 4 no response
  task automatic serve(input int mode, input logic [7:0] q, input logic [7:0] r, input bit accept,
                       output bit started, output logic [15:0] dvd, output logic [7:0] dvs,
                       output int fin_pulses, output int fin_at, output bit got_res,
                       output logic [7:0] gq, output logic [7:0] gr, output logic [1:0] gerr);
    int n, k;
    started = 0; dvd = '0; dvs = '0; fin_pulses = 0; fin_at = -1;
    got_res = 0; gq = '0; gr = '0; gerr = '0;
    n = 0;
    while (!core_start && n < 40) begin
      tick();
      n++;
    end
    if (!core_start) return;
    started = 1;
    dvd = core_dividend;
    dvs = core_divisor;
    k = 0;
    tick();
    k++;
    case (mode)
      0: begin core_done = 1'b1; core_quotient = q; core_remainder = r; end
      1: core_divby0 = 1'b1;
      2: core_overflow = 1'b1;
      3: begin core_divby0 = 1'b1; core_overflow = 1'b1; end
      default: ;
    endcase
    while (!res_valid && k < 150) begin
      tick();
      k++;
      core_done = 1'b0;
      if (core_finish) begin
        fin_pulses++;
        if (fin_at < 0) fin_at = k;
      end
    end
    core_divby0   = 1'b0;
    core_overflow = 1'b0;
    if (!res_valid) return;
    got_res = 1;
    gq = res_quotient;
    gr = res_remainder;
    gerr = res_err;
    if (accept) begin
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      if (core_finish) fin_pulses++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_core_start got %b expected 0", core_start); end
    vectors++; if (core_finish !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_core_finish got %b expected 0", core_finish); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_valid got %b expected 0", res_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
    vectors++; if ({core_dividend, core_divisor, res_quotient, res_remainder, res_err} !== 42'd0) begin
      miscompares++; $display("[TB] FAIL reset_data got %h expected 0", {core_dividend, core_divisor, res_quotient, res_remainder, res_err});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push(16'd100, 8'd7);
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_start_early got %b expected 0", core_start); end
    tick();
    vectors++; if (core_start !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_start_latency got %b expected 1", core_start); end
    vectors++; if ({core_dividend, core_divisor} !== {16'd100, 8'd7}) begin
      miscompares++; $display("[TB] FAIL basic_operands got %0d/%0d expected 100/7", core_dividend, core_divisor);
    end
    tick();
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_start_width got %b expected 0", core_start); end
    core_done = 1'b1; core_quotient = 8'd14; core_remainder = 8'd2;
    tick();
    core_done = 1'b0; core_quotient = 8'hAA; core_remainder = 8'h55;
    tick();
    tick();
    vectors++; if ({res_valid, res_quotient, res_remainder, res_err} !== {1'b1, 8'd14, 8'd2, 2'b00}) begin
      miscompares++; $display("[TB] FAIL basic_result got v=%b q=%0d r=%0d e=%b expected v=1 q=14 r=2 e=00", res_valid, res_quotient, res_remainder, res_err);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_res_drop got %b expected 0", res_valid); end
  endtask

  task automatic test_divby0();
    bit st, gr_ok; logic [15:0] dvd; logic [7:0] dvs, gq, grm; logic [1:0] ge; int fp, fa;
    push(16'd50, 8'd0);
    serve(1, 8'd0, 8'd0, 1'b1, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
    vectors++; if ({st, gr_ok, dvd, dvs} !== {2'b11, 16'd50, 8'd0}) begin
      miscompares++; $display("[TB] FAIL divby0_issue got st=%b res=%b %0d/%0d expected 1 1 50/0", st, gr_ok, dvd, dvs);
    end
    vectors++; if (fp !== 1 || fa !== 2) begin miscompares++; $display("[TB] FAIL divby0_finish got pulses=%0d at=%0d expected 1 at 2", fp, fa); end
    vectors++; if ({gq, grm, ge} !== {8'd0, 8'd0, 2'b01}) begin
      miscompares++; $display("[TB] FAIL divby0_result got q=%0d r=%0d e=%b expected 0 0 01", gq, grm, ge);
    end
    push(16'd9, 8'd2);
    serve(0, 8'd4, 8'd1, 1'b1, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
    vectors++; if ({st, gr_ok, dvd, dvs, gq, grm, ge, fp[7:0]} !== {2'b11, 16'd9, 8'd2, 8'd4, 8'd1, 2'b00, 8'd0}) begin
      miscompares++; $display("[TB] FAIL divby0_next_job got q=%0d r=%0d e=%b fin=%0d expected 4 1 00 0", gq, grm, ge, fp);
    end
  endtask

  task automatic test_overflow();
    bit st, gr_ok; logic [15:0] dvd; logic [7:0] dvs, gq, grm; logic [1:0] ge; int fp, fa;
    push(16'h0800, 8'd2);
    serve(2, 8'd0, 8'd0, 1'b1, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
    vectors++; if ({st, gr_ok, dvd, gq, grm, ge} !== {2'b11, 16'h0800, 8'd0, 8'd0, 2'b10} || fp !== 1) begin
      miscompares++; $display("[TB] FAIL overflow_result got q=%0d r=%0d e=%b fin=%0d expected 0 0 10 1", gq, grm, ge, fp);
    end
    push(16'h0800, 8'd2);
    serve(3, 8'd0, 8'd0, 1'b1, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
    vectors++; if ({st, gr_ok, ge} !== {2'b11, 2'b01} || fp !== 1) begin
      miscompares++; $display("[TB] FAIL both_flags_priority got e=%b fin=%0d expected 01 1", ge, fp);
    end
  endtask

  task automatic test_timeout();
    bit st, gr_ok; logic [15:0] dvd; logic [7:0] dvs, gq, grm; logic [1:0] ge; int fp, fa;
    push(16'd1234, 8'd3);
    serve(4, 8'd0, 8'd0, 1'b1, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
    vectors++; if (fp !== 1 || fa !== 65) begin miscompares++; $display("[TB] FAIL timeout_finish got pulses=%0d at=%0d expected 1 at 65", fp, fa); end
    vectors++; if ({st, gr_ok, gq, grm, ge} !== {2'b11, 8'd0, 8'd0, 2'b11}) begin
      miscompares++; $display("[TB] FAIL timeout_result got res=%b q=%0d r=%0d e=%b expected 1 0 0 11", gr_ok, gq, grm, ge);
    end
  endtask

  task automatic test_back_to_back();
    bit st, gr_ok; logic [15:0] dvd; logic [7:0] dvs, gq, grm; logic [1:0] ge; int fp, fa, base;
    logic [15:0] exp_d [5] = '{16'd77, 16'd255, 16'h1234, 16'd200, 16'd300};
    logic [7:0]  exp_v [5] = '{8'd5, 8'd16, 8'h40, 8'd3, 8'd7};
    logic [7:0]  exp_q [5] = '{8'd15, 8'd15, 8'd72, 8'd66, 8'd42};
    logic [7:0]  exp_r [5] = '{8'd2, 8'd15, 8'd52, 8'd2, 8'd6};
    base = accepted;
    push(16'd1000, 8'd10);
    serve(0, 8'd100, 8'd0, 1'b0, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_before_push%0d got %b expected 1", i, in_ready); end
      push(exp_d[i], exp_v[i]);
    end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full got in_ready=%b expected 0", in_ready); end
    push(exp_d[4], exp_v[4]);
    tick();
    tick();
    vectors++; if (accepted - base !== 5) begin miscompares++; $display("[TB] FAIL b2b_held_push got accepted=%0d expected 5", accepted - base); end
    vectors++; if ({res_valid, res_quotient, res_remainder, res_err} !== {1'b1, 8'd100, 8'd0, 2'b00}) begin
      miscompares++; $display("[TB] FAIL b2b_stalled_result got v=%b q=%0d r=%0d expected 1 100 0", res_valid, res_quotient, res_remainder);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      serve(0, exp_q[i], exp_r[i], 1'b1, st, dvd, dvs, fp, fa, gr_ok, gq, grm, ge);
      vectors++; if ({st, gr_ok, dvd, dvs, gq, grm, ge} !== {2'b11, exp_d[i], exp_v[i], exp_q[i], exp_r[i], 2'b00}) begin
        miscompares++; $display("[TB] FAIL b2b_job%0d got %0d/%0d q=%0d r=%0d e=%b expected %0d/%0d q=%0d r=%0d e=00",
                                i, dvd, dvs, gq, grm, ge, exp_d[i], exp_v[i], exp_q[i], exp_r[i]);
      end
    end
    vectors++; if (accepted - base !== 6) begin miscompares++; $display("[TB] FAIL b2b_late_accept got accepted=%0d expected 6", accepted - base); end
  endtask

  task automatic test_reset_mid_job();
    bit saw_start, saw_res;
    push(16'd10, 8'd1);
    push(16'd20, 8'd2);
    push(16'd30, 8'd3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    vectors++; if ({core_start, core_finish, res_valid, in_ready} !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL midrst_ctrl got start=%b fin=%b valid=%b ready=%b expected 0 0 0 1", core_start, core_finish, res_valid, in_ready);
    end
    vectors++; if ({core_dividend, core_divisor, res_err} !== 26'd0) begin
      miscompares++; $display("[TB] FAIL midrst_data got %h expected 0", {core_dividend, core_divisor, res_err});
    end
    tick();
    rst = 1'b0;
    saw_start = 0;
    saw_res = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_start) saw_start = 1;
      if (res_valid) saw_res = 1;
    end
    vectors++; if ({saw_start, saw_res} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL midrst_queue_lost got start=%b res=%b expected 0 0", saw_start, saw_res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divby0();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
